// File: rtl/rob_req_tagger_pkg.sv
// Shared ROB types and default widths for the request-tagging stage.
package rob_package;

    localparam int AWIDTH  = 32;
    localparam int IDWIDTH = 4;
    localparam int PWIDTH  = 4;
    localparam int DWIDTH  = 32;

    localparam int ROB_DEPTH = 2**IDWIDTH;

    typedef logic [IDWIDTH-1:0] rob_id_t;
    typedef logic [IDWIDTH:0]   rob_cnt_t;

    typedef struct packed {
        logic [AWIDTH-1:0] addr;
        logic [PWIDTH-1:0] param;
        logic [DWIDTH-1:0] data;
    } rob_req_t;

endpackage

// File: rtl/rob_tag_ctr.sv
// ROB ID bookkeeping: allocation/retire pointers and in-flight count.
// Optional ROB_TAG_CHECK_EN adds a sticky retire-protocol error flag.
module rob_tag_ctr
    import rob_package::*;
#(
    parameter int IDWIDTH = rob_package::IDWIDTH
) (
    input  logic               clk,
    input  logic               rst_,
    input  logic               alloc,
    input  logic               retire,
    input  logic [IDWIDTH-1:0] ret_id,
    output logic [IDWIDTH-1:0] next_id,
    output logic [IDWIDTH:0]   outstanding,
    output logic               full,
    output logic               empty,
    output logic               err
);

    localparam logic [IDWIDTH:0] DEPTH = (IDWIDTH+1)'(2**IDWIDTH);

    // One extra bit on each pointer so the difference spans 0..DEPTH.
    logic [IDWIDTH:0] alloc_ptr;
    logic [IDWIDTH:0] ret_ptr;
    logic             retire_ok;

    assign outstanding = alloc_ptr - ret_ptr;
    assign full        = (outstanding == DEPTH);
    assign empty       = (outstanding == '0);
    assign next_id     = alloc_ptr[IDWIDTH-1:0];
    assign retire_ok   = retire && !empty;

    // Pointer advance; a retire with nothing outstanding is ignored.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            alloc_ptr <= '0;
            ret_ptr   <= '0;
        end else begin
            if (alloc)     alloc_ptr <= alloc_ptr + 1'b1;
            if (retire_ok) ret_ptr   <= ret_ptr + 1'b1;
        end
    end

`ifdef ROB_TAG_CHECK_EN
    // Sticky flag: out-of-order retire ID or retire with nothing in flight.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_)
            err <= 1'b0;
        else if (retire && (empty || ret_id != ret_ptr[IDWIDTH-1:0]))
            err <= 1'b1;
    end
`else
    logic unused_ret_id;
    assign unused_ret_id = ^ret_id;
    assign err           = 1'b0;
`endif

endmodule

// File: rtl/rob_req_tagger.sv
// Tags upstream requests with sequential ROB IDs behind one registered
// output stage; stalls upstream when every ID is in flight.
// Optional build macro: ROB_TAG_CHECK_EN (retire ID checking, err output).
module rob_req_tagger
    import rob_package::*;
#(
    parameter int AWIDTH  = rob_package::AWIDTH,
    parameter int IDWIDTH = rob_package::IDWIDTH,
    parameter int PWIDTH  = rob_package::PWIDTH,
    parameter int DWIDTH  = rob_package::DWIDTH
) (
    input  logic               clk,
    input  logic               rst_,
    input  logic               in_val,
    input  logic [AWIDTH-1:0]  in_addr,
    input  logic [PWIDTH-1:0]  in_param,
    input  logic [DWIDTH-1:0]  in_data,
    output logic               in_ready,
    output logic               val,
    output logic [AWIDTH-1:0]  addr,
    output logic [IDWIDTH-1:0] ID,
    output logic [PWIDTH-1:0]  param,
    output logic [DWIDTH-1:0]  data,
    input  logic               ready,
    input  logic               ret_val,
    input  logic [IDWIDTH-1:0] ret_ID,
    output logic [IDWIDTH:0]   outstanding,
    output logic               err
);

    logic               capture;
    logic               full;
    logic               empty;
    logic [IDWIDTH-1:0] next_id;

    // Output slot frees when empty or draining this cycle; no ID, no capture.
    assign in_ready = !full && (!val || ready);
    assign capture  = in_val && in_ready;

    rob_tag_ctr #(
        .IDWIDTH (IDWIDTH)
    ) u_ctr (
        .clk         (clk),
        .rst_        (rst_),
        .alloc       (capture),
        .retire      (ret_val),
        .ret_id      (ret_ID),
        .next_id     (next_id),
        .outstanding (outstanding),
        .full        (full),
        .empty       (empty),
        .err         (err)
    );

    // Output register: load on capture, hold while stalled, drop when taken.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            val   <= 1'b0;
            addr  <= '0;
            ID    <= '0;
            param <= '0;
            data  <= '0;
        end else if (capture) begin
            val   <= 1'b1;
            addr  <= in_addr;
            ID    <= next_id;
            param <= in_param;
            data  <= in_data;
        end else if (ready) begin
            val   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rob_req_tagger.sv
// Directed bench for rob_req_tagger with IDWIDTH=2 (four IDs).
module tb_rob_req_tagger;
    localparam int AW = 8;
    localparam int IW = 2;
    localparam int PW = 4;
    localparam int DW = 8;

`ifdef ROB_TAG_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_;
    logic          in_val;
    logic [AW-1:0] in_addr;
    logic [PW-1:0] in_param;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          val;
    logic [AW-1:0] addr;
    logic [IW-1:0] ID;
    logic [PW-1:0] param;
    logic [DW-1:0] data;
    logic          ready;
    logic          ret_val;
    logic [IW-1:0] ret_ID;
    logic [IW:0]   outstanding;
    logic          err;

    int total = 0;
    int bad   = 0;

    rob_req_tagger #(.AWIDTH(AW), .IDWIDTH(IW), .PWIDTH(PW), .DWIDTH(DW)) dut (
        .clk(clk), .rst_(rst_), .in_val(in_val), .in_addr(in_addr),
        .in_param(in_param), .in_data(in_data), .in_ready(in_ready),
        .val(val), .addr(addr), .ID(ID), .param(param), .data(data),
        .ready(ready), .ret_val(ret_val), .ret_ID(ret_ID),
        .outstanding(outstanding), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_ = 1'b0; in_val = 1'b0; in_addr = '0; in_param = '0; in_data = '0;
        ready = 1'b1; ret_val = 1'b0; ret_ID = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_val", 32'(val), 32'd0);
        check("rst_id", 32'(ID), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_outstanding", 32'(outstanding), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst_ = 1'b1;
        tick();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // four back-to-back captures fill every ID
        for (int i = 0; i < 4; i++) begin
            in_val = 1'b1; in_addr = 8'h10 + 8'(i); in_param = 4'(i); in_data = 8'hA0 + 8'(i);
            check("fill_in_ready", 32'(in_ready), 32'd1);
            tick();
            check("fill_val", 32'(val), 32'd1);
            check("fill_id", 32'(ID), 32'(i));
            check("fill_addr", 32'(addr), 32'h10 + 32'(i));
            check("fill_param", 32'(param), 32'(i));
            check("fill_data", 32'(data), 32'hA0 + 32'(i));
            check("fill_outstanding", 32'(outstanding), 32'(i + 1));
        end
        in_addr = 8'h55;
        check("full_in_ready", 32'(in_ready), 32'd0);
        tick();
        check("full_no_capture_val", 32'(val), 32'd0);
        check("full_outstanding", 32'(outstanding), 32'd4);
        check("full_id_held", 32'(ID), 32'd3);
        check("full_in_ready2", 32'(in_ready), 32'd0);

        // retire oldest while full, then capture wraps to ID 0
        in_val = 1'b0; ret_val = 1'b1; ret_ID = 2'd0;
        tick();
        ret_val = 1'b0;
        check("ret_outstanding", 32'(outstanding), 32'd3);
        check("ret_in_ready", 32'(in_ready), 32'd1);
        in_val = 1'b1; in_addr = 8'h66;
        tick();
        in_val = 1'b0;
        check("wrap_id", 32'(ID), 32'd0);
        check("wrap_addr", 32'(addr), 32'h66);
        check("wrap_outstanding", 32'(outstanding), 32'd4);
        check("wrap_in_ready", 32'(in_ready), 32'd0);
        ret_val = 1'b1; ret_ID = 2'd1;
        tick();
        ret_ID = 2'd2;
        tick();
        ret_val = 1'b0;
        check("drain_outstanding", 32'(outstanding), 32'd2);

        // downstream stall holds the output register and upstream
        ready = 1'b0; in_val = 1'b1; in_addr = 8'h77; in_param = 4'h7; in_data = 8'h99;
        check("stall_pre_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_addr = 8'h88; in_param = 4'h8; in_data = 8'h11;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_val", 32'(val), 32'd1);
            check("stall_id", 32'(ID), 32'd1);
            check("stall_addr", 32'(addr), 32'h77);
            check("stall_param", 32'(param), 32'h7);
            check("stall_data", 32'(data), 32'h99);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_outstanding", 32'(outstanding), 32'd3);
        end
        in_val = 1'b0; ready = 1'b1;
        tick();
        check("stall_release_val", 32'(val), 32'd0);

        // capture and retire in the same cycle
        ret_val = 1'b1; ret_ID = 2'd3;
        tick();
        check("pre_both_outstanding", 32'(outstanding), 32'd2);
        in_val = 1'b1; in_addr = 8'hC0; ret_ID = 2'd0;
        tick();
        in_val = 1'b0; ret_val = 1'b0;
        check("both_outstanding", 32'(outstanding), 32'd2);
        check("both_id", 32'(ID), 32'd2);
        check("both_val", 32'(val), 32'd1);
        ret_val = 1'b1; ret_ID = 2'd1;
        tick();
        ret_ID = 2'd2;
        tick();
        ret_val = 1'b0;
        check("empty_outstanding", 32'(outstanding), 32'd0);
        check("in_order_err", 32'(err), 32'd0);

        // underflow retire
        ret_val = 1'b1; ret_ID = 2'd3;
        tick();
        ret_val = 1'b0;
        check("underflow_outstanding", 32'(outstanding), 32'd0);
        check("underflow_err", 32'(err), 32'(EXP_ERR));
        check("underflow_in_ready", 32'(in_ready), 32'd1);

        rst_ = 1'b0;
        #1;
        check("rst2_err", 32'(err), 32'd0);
        check("rst2_outstanding", 32'(outstanding), 32'd0);
        tick();
        rst_ = 1'b1;
        tick();

        // out-of-order retire ID
        in_val = 1'b1; in_addr = 8'hD0;
        tick();
        in_val = 1'b0;
        check("mm_id", 32'(ID), 32'd0);
        check("mm_pre_outstanding", 32'(outstanding), 32'd1);
        ret_val = 1'b1; ret_ID = 2'd3;
        tick();
        ret_val = 1'b0;
        check("mm_outstanding", 32'(outstanding), 32'd0);
        check("mm_err", 32'(err), 32'(EXP_ERR));
        in_val = 1'b1; in_addr = 8'hE0;
        tick();
        in_val = 1'b0;
        check("mm_next_id", 32'(ID), 32'd1);
        check("mm_err_sticky", 32'(err), 32'(EXP_ERR));
        check("mm_val", 32'(val), 32'd1);

        // asynchronous reset mid-stream
        rst_ = 1'b0;
        #1;
        check("async_rst_val", 32'(val), 32'd0);
        check("async_rst_outstanding", 32'(outstanding), 32'd0);
        check("async_rst_err", 32'(err), 32'd0);
        check("async_rst_id", 32'(ID), 32'd0);
        tick();
        rst_ = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
